// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hazard_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Largest supported load-use bubble count and the width of the bubble counter
    localparam int LOAD_LAT_MAX = 3;
    localparam int BUB_W        = 2;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Purpose: two free-running 32-bit event counters (stall cycles, IFID flushes), wrap modulo 2^32.
// Latency: count visible one cycle after the event.
// Backpressure: none; counts every cycle its increment input is high, cleared by rst_i.
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_inc_i,
    input  logic        flush_inc_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Next counts: plain increment, wrapping naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall_inc_i);
        flush_cnt_d = flush_cnt_q + 32'(flush_inc_i);
    end

    // Counter registers, synchronously cleared
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: 5-stage pipeline hazard controller (load-use, branch flush, fetch wait, dmem freeze); HAZARD_PERF_CNT_EN enables perf counters.
// Latency: zero-cycle; controls are combinational from registered state plus current inputs.
// Backpressure: dmem_busy_i freezes the whole pipe; imem_ack_i=0 holds the PC and bubbles IFID.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] IFID_rs1_i,
    input  logic [REG_AW-1:0] IFID_rs2_i,
    input  logic              IDEX_MemRead_i,
    input  logic [REG_AW-1:0] IDEX_rd_i,
    input  logic              branch_taken_i,
    input  logic              imem_ack_i,
    input  logic              dmem_busy_i,
    output logic              PC_write_o,
    output logic              IFID_Stall_o,
    output logic              IFID_Flush_o,
    output logic              IDEX_Flush_o,
    output logic              freeze_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    // Out-of-range parameter values are clamped into 1..LOAD_LAT_MAX
    localparam int LAT = (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX :
                         (LOAD_LAT < 1)            ? 1 : LOAD_LAT;

    hazard_state_e    state_q, state_d;
    hazard_state_e    ret_state_q, ret_state_d;
    hazard_state_e    eff_state;
    logic [BUB_W-1:0] bub_cnt_q, bub_cnt_d;
    logic             lu_hit;

    // Load in EX writes a register the instruction in ID reads
    assign lu_hit = IDEX_MemRead_i
                  && (IDEX_rd_i != REG_AW'(REG_ZERO))
                  && ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));

    // Next-state and output decode, priority: reset > dmem wait > load-use > branch > fetch wait
    always_comb begin
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        bub_cnt_d    = bub_cnt_q;
        eff_state    = state_q;
        PC_write_o   = 1'b1;
        IFID_Stall_o = 1'b0;
        IFID_Flush_o = 1'b0;
        IDEX_Flush_o = 1'b0;
        freeze_o     = 1'b0;

        if (rst_i) begin
            state_d      = RUN;
            ret_state_d  = RUN;
            bub_cnt_d    = '0;
            PC_write_o   = 1'b0;
            IFID_Flush_o = 1'b1;
            IDEX_Flush_o = 1'b1;
        end else if (dmem_busy_i) begin
            PC_write_o   = 1'b0;
            IFID_Stall_o = 1'b1;
            freeze_o     = 1'b1;
            // Remember where to resume; the bubble count is left untouched
            if (state_q != MEM_WAIT) begin
                ret_state_d = state_q;
                state_d     = MEM_WAIT;
            end
        end else begin
            // Leaving MEM_WAIT behaves exactly like the state it interrupted
            eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;
            state_d   = eff_state;
            case (eff_state)
                LU_STALL: begin
                    PC_write_o   = 1'b0;
                    IFID_Stall_o = 1'b1;
                    IDEX_Flush_o = 1'b1;
                    bub_cnt_d    = bub_cnt_q - 1'b1;
                    if (bub_cnt_q <= BUB_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (lu_hit) begin
                        PC_write_o   = 1'b0;
                        IFID_Stall_o = 1'b1;
                        IDEX_Flush_o = 1'b1;
                        // This cycle is the first bubble; LU_STALL supplies the rest
                        if (LAT > 1) begin
                            bub_cnt_d = BUB_W'(LAT - 1);
                            state_d   = LU_STALL;
                        end
                    end else if (branch_taken_i) begin
                        IFID_Flush_o = 1'b1;
                    end else if (!imem_ack_i) begin
                        PC_write_o   = 1'b0;
                        IFID_Flush_o = 1'b1;
                    end
                end
            endcase
        end
    end

    // State registers, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            ret_state_q <= RUN;
            bub_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            bub_cnt_q   <= bub_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_inc_i (~PC_write_o & ~rst_i),
        .flush_inc_i (IFID_Flush_o & ~rst_i),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed self-checking bench for hazard_ctrl at LOAD_LAT = 1, 2 and 3.
// Latency: outputs checked combinationally, one step after inputs are driven.
// Backpressure: dmem_busy_i and imem_ack_i driven as directed vectors.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output patterns packed as {PC_write, IFID_Stall, IFID_Flush, IDEX_Flush, freeze}
    localparam logic [4:0] O_RUN   = 5'b10000;
    localparam logic [4:0] O_STALL = 5'b01010;
    localparam logic [4:0] O_BR    = 5'b10100;
    localparam logic [4:0] O_FETCH = 5'b00100;
    localparam logic [4:0] O_FRZ   = 5'b01001;
    localparam logic [4:0] O_RST   = 5'b00110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       memrd, br, ack, busy;

    logic        pc1, st1, if1, id1, fz1;
    logic        pc2, st2, if2, id2, fz2;
    logic        pc3, st3, if3, id3, fz3;
    logic [31:0] sc1, fc1, sc2, fc2, sc3, fc3;
    logic [4:0]  o1, o2, o3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign o1 = {pc1, st1, if1, id1, fz1};
    assign o2 = {pc2, st2, if2, id2, fz2};
    assign o3 = {pc3, st3, if3, id3, fz3};

    hazard_ctrl #(.LOAD_LAT(1), .REG_AW(5)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
        .IDEX_MemRead_i(memrd), .IDEX_rd_i(rd), .branch_taken_i(br),
        .imem_ack_i(ack), .dmem_busy_i(busy),
        .PC_write_o(pc1), .IFID_Stall_o(st1), .IFID_Flush_o(if1),
        .IDEX_Flush_o(id1), .freeze_o(fz1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    hazard_ctrl #(.LOAD_LAT(2), .REG_AW(5)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
        .IDEX_MemRead_i(memrd), .IDEX_rd_i(rd), .branch_taken_i(br),
        .imem_ack_i(ack), .dmem_busy_i(busy),
        .PC_write_o(pc2), .IFID_Stall_o(st2), .IFID_Flush_o(if2),
        .IDEX_Flush_o(id2), .freeze_o(fz2), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    hazard_ctrl #(.LOAD_LAT(3), .REG_AW(5)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
        .IDEX_MemRead_i(memrd), .IDEX_rd_i(rd), .branch_taken_i(br),
        .imem_ack_i(ack), .dmem_busy_i(busy),
        .PC_write_o(pc3), .IFID_Stall_o(st3), .IFID_Flush_o(if3),
        .IDEX_Flush_o(id3), .freeze_o(fz3), .stall_cnt_o(sc3), .flush_cnt_o(fc3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0;
        memrd = 1'b0; br = 1'b0; ack = 1'b1; busy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
    endtask

    // Present a load-use pair: load to x5 in EX, ID reads x5 on rs1
    task automatic load_use();
        memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd2;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check("rst_outputs", 32'(o1), 32'(O_RST));
        cyc();
        #1;
        check("rst_stall_cnt", sc3, 32'd0);
        check("rst_flush_cnt", fc3, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_run", 32'(o1), 32'(O_RUN));

        // Load-use, LOAD_LAT=1: one bubble then normal run
        load_use(); #1;
        check("lu1_bubble", 32'(o1), 32'(O_STALL));
        cyc(); idle(); #1;
        check("lu1_after", 32'(o1), 32'(O_RUN));
        memrd = 1'b1; rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; #1;
        check("lu1_rs2_hit", 32'(o1), 32'(O_STALL));
        rs2 = 5'd4; #1;
        check("lu1_no_match", 32'(o1), 32'(O_RUN));
        memrd = 1'b0; rs2 = 5'd7; #1;
        check("lu1_not_load", 32'(o1), 32'(O_RUN));

        // Load-use, LOAD_LAT=2: exactly two bubbles
        do_reset();
        load_use(); #1;
        check("lu2_bubble1", 32'(o2), 32'(O_STALL));
        cyc(); idle(); #1;
        check("lu2_bubble2", 32'(o2), 32'(O_STALL));
        cyc(); #1;
        check("lu2_done", 32'(o2), 32'(O_RUN));
        memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; #1;
        check("lu2_x0_no_stall", 32'(o2), 32'(O_RUN));

        // Taken branch: one-cycle IFID flush; with load-use the stall wins
        do_reset();
        br = 1'b1; #1;
        check("br_flush", 32'(o1), 32'(O_BR));
        cyc(); br = 1'b0; #1;
        check("br_after", 32'(o1), 32'(O_RUN));
        load_use(); br = 1'b1; #1;
        check("br_lu_stall1", 32'(o1), 32'(O_STALL));
        check("br_lu_stall2", 32'(o2), 32'(O_STALL));
        cyc(); idle(); br = 1'b1; #1;
        check("br_lu_reresolve1", 32'(o1), 32'(O_BR));
        check("br_lu_still_stall2", 32'(o2), 32'(O_STALL));
        cyc(); #1;
        check("br_lu_reresolve2", 32'(o2), 32'(O_BR));
        cyc(); br = 1'b0; #1;
        check("br_lu_run", 32'(o1), 32'(O_RUN));

        // Fetch wait: two cycles of fetch bubbles; branch outranks it
        ack = 1'b0; #1;
        check("imem_wait1", 32'(o1), 32'(O_FETCH));
        cyc(); #1;
        check("imem_wait2", 32'(o1), 32'(O_FETCH));
        br = 1'b1; #1;
        check("imem_wait_branch", 32'(o1), 32'(O_BR));
        cyc(); idle(); #1;
        check("imem_ack_run", 32'(o1), 32'(O_RUN));

        // LOAD_LAT=3 with a dmem freeze after the first bubble, preceded by one fetch wait
        do_reset();
        ack = 1'b0; #1;
        check("s4_fetch", 32'(o3), 32'(O_FETCH));
        cyc(); ack = 1'b1; load_use(); #1;
        check("s4_bubble1", 32'(o3), 32'(O_STALL));
        cyc(); idle(); busy = 1'b1; #1;
        check("s4_freeze1", 32'(o3), 32'(O_FRZ));
        cyc(); #1;
        check("s4_freeze2", 32'(o3), 32'(O_FRZ));
        cyc(); #1;
        check("s4_freeze3", 32'(o3), 32'(O_FRZ));
        cyc(); busy = 1'b0; #1;
        check("s4_bubble2", 32'(o3), 32'(O_STALL));
        cyc(); #1;
        check("s4_bubble3", 32'(o3), 32'(O_STALL));
        cyc(); #1;
        check("s4_run", 32'(o3), 32'(O_RUN));
        check("s4_stall_cnt", sc3, PERF ? 32'd7 : 32'd0);
        check("s4_flush_cnt", fc3, PERF ? 32'd1 : 32'd0);

        // Reset while in MEM_WAIT: reset outranks busy, then RUN with counters cleared
        busy = 1'b1; #1;
        check("s6_freeze", 32'(o3), 32'(O_FRZ));
        cyc(); rst = 1'b1; #1;
        check("s6_rst_over_busy", 32'(o3), 32'(O_RST));
        cyc(); rst = 1'b0; busy = 1'b0; #1;
        check("s6_run", 32'(o3), 32'(O_RUN));
        check("s6_stall_cnt", sc3, 32'd0);
        check("s6_flush_cnt", fc3, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
